// File: rtl/ras_circ.sv
// Circular return-address stack: DEPTH entries, wrapping top pointer, saturating count.
// Optional checkpoint/restore of {tp, count, entry[tp]} when RAS_CIRC_CKPT_EN is defined.
module ras_circ #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
`ifdef RAS_CIRC_CKPT_EN
    input  logic                       ckpt_i,
    input  logic                       restore_i,
`endif
    input  logic [XLEN-1:0]            data_i,
    output logic [XLEN-1:0]            data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ras_circ: DEPTH must be a power of two and at least 2");
    end

    // push_i/pop_i are single-cycle requests that are always accepted; there is no backpressure.
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [PW-1:0]   tp_q, tp_d, tp_inc, tp_dec;
    logic [CW-1:0]   count_q, count_d;

`ifdef RAS_CIRC_CKPT_EN
    logic [PW-1:0]   snap_tp_q, snap_tp_d;
    logic [CW-1:0]   snap_count_q, snap_count_d;
    logic [XLEN-1:0] snap_addr_q, snap_addr_d;
`endif

    assign tp_inc = tp_q + PW'(1);
    assign tp_dec = tp_q - PW'(1);

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_i) begin
            tp_d    = '0;
            count_d = '0;
`ifdef RAS_CIRC_CKPT_EN
        end else if (restore_i) begin
            tp_d             = snap_tp_q;
            count_d          = snap_count_q;
            mem_d[snap_tp_q] = snap_addr_q;
`endif
        end else if (push_i && pop_i) begin
            mem_d[tp_q] = data_i;
            if (count_q == '0) begin
                count_d = CW'(1);
            end
        end else if (push_i) begin
            // When full, tp+1 lands on the oldest slot, so overflow overwrites it.
            tp_d          = tp_inc;
            mem_d[tp_inc] = data_i;
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop_i && count_q != '0) begin
            tp_d    = tp_dec;
            count_d = count_q - CW'(1);
        end
    end

`ifdef RAS_CIRC_CKPT_EN
    // A restore leaves the snapshot alone, which is exactly the state being restored.
    always_comb begin
        snap_tp_d    = snap_tp_q;
        snap_count_d = snap_count_q;
        snap_addr_d  = snap_addr_q;
        if (ckpt_i && !restore_i) begin
            snap_tp_d    = tp_q;
            snap_count_d = count_q;
            snap_addr_d  = mem_q[tp_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_tp_q    <= '0;
            snap_count_q <= '0;
            snap_addr_q  <= '0;
        end else begin
            snap_tp_q    <= snap_tp_d;
            snap_count_q <= snap_count_d;
            snap_addr_q  <= snap_addr_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign data_o  = mem_q[tp_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: tb/tb_ras_circ.sv
// Bench for ras_circ (XLEN=32, DEPTH=4): directed scenarios plus random traffic,
// checked by a queue-based stack model through an expected-response scoreboard.
module tb_ras_circ;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int W     = 1 + CW + XLEN;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i, push_i, pop_i;
    logic            ckpt_i, restore_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;
    logic            valid_o;
    logic [CW-1:0]   count_o;

    ras_circ #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (push_i),
        .pop_i    (pop_i),
`ifdef RAS_CIRC_CKPT_EN
        .ckpt_i   (ckpt_i),
        .restore_i(restore_i),
`endif
        .data_i   (data_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .count_o  (count_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: a plain stack of return addresses, oldest at index 0
    logic [XLEN-1:0] stk[$];
    logic [XLEN-1:0] snap_stk[$];

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           due_q[$];

    task automatic model_update(input logic f, input logic pu, input logic po,
                                input logic [XLEN-1:0] d, input logic ck, input logic rs);
        if (ck && !rs) snap_stk = stk;
        if (f) begin
            stk.delete();
        end else if (rs) begin
            stk = snap_stk;
        end else if (pu && po) begin
            if (stk.size() == 0) stk.push_back(d);
            else stk[stk.size()-1] = d;
        end else if (pu) begin
            stk.push_back(d);
            if (stk.size() > DEPTH) void'(stk.pop_front());
        end else if (po && stk.size() > 0) begin
            void'(stk.pop_back());
        end
    endtask

    // driver: one request per call, captured at the next rising edge
    task automatic step(input logic f, input logic pu, input logic po, input logic [XLEN-1:0] d,
                        input logic ck = 1'b0, input logic rs = 1'b0);
        logic [XLEN-1:0] top;
        @(posedge clk_i);
        #1;
        flush_i   = f;
        push_i    = pu;
        pop_i     = po;
        data_i    = d;
        ckpt_i    = ck;
        restore_i = rs;
        model_update(f, pu, po, d, ck, rs);
        top = (stk.size() != 0) ? stk[stk.size()-1] : '0;
        exp_q.push_back({stk.size() != 0, CW'(stk.size()), top});
        due_q.push_back(cyc + 1);
    endtask

    // monitor: compares on the falling edge after the update edge
    always @(negedge clk_i) begin
        logic [W-1:0] e;
        while (exp_q.size() != 0 && due_q[0] == cyc) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            n_tests++;
            if (valid_o !== e[W-1] || count_o !== e[XLEN+CW-1:XLEN] ||
                (e[W-1] && data_o !== e[XLEN-1:0])) begin
                n_fail++;
                $display("FAIL sb cyc=%0d: got data=%h valid=%b count=%0d, want data=%h valid=%b count=%0d",
                         cyc, data_o, valid_o, count_o, e[XLEN-1:0], e[W-1], e[XLEN+CW-1:XLEN]);
            end
        end
    end

    task automatic check_out(input string name, input logic [XLEN-1:0] ed, input logic ev,
                             input logic [CW-1:0] ec);
        n_tests++;
        if (data_o !== ed || valid_o !== ev || count_o !== ec) begin
            n_fail++;
            $display("FAIL %s: got data=%h valid=%b count=%0d, want data=%h valid=%b count=%0d",
                     name, data_o, valid_o, count_o, ed, ev, ec);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expectations left, want 0", name, exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 0; push_i = 0; pop_i = 0;
        ckpt_i = 0; restore_i = 0; data_i = '0;
        #3;
        check_out("reset_before_clock", '0, 1'b0, '0);
        @(posedge clk_i); @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // basic push/pop
        step(0, 1, 0, 32'h100);
        step(0, 1, 0, 32'h200);
        step(0, 0, 1, '0);

        // overflow then drain to empty
        step(1, 0, 0, '0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, XLEN'(i * 'h10));
        for (int i = 0; i < 4; i++) step(0, 0, 1, '0);

        // underflow ignored, then push
        step(0, 0, 1, '0);
        step(0, 1, 0, 32'hA0);

        // simultaneous push+pop replaces the top
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'h80);
        step(0, 1, 0, 32'h100);
        step(0, 1, 1, 32'h300);
        step(0, 0, 1, '0);
        step(0, 1, 1, 32'h44);
        step(0, 0, 1, '0);
        step(0, 1, 1, 32'h55);

        // flush beats push
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'h1);
        step(0, 1, 0, 32'h2);
        step(0, 1, 0, 32'h3);
        step(1, 1, 0, 32'h999);
        step(0, 1, 0, 32'h4);
        step(0, 1, 0, 32'h5);
        drain("drain_directed");

        // asynchronous reset in the middle of a push
        @(posedge clk_i);
        #1 push_i = 1'b1; data_i = 32'hDEAD;
        #2 rst_ni = 1'b0;
        #1 check_out("reset_mid_push", '0, 1'b0, '0);
        @(posedge clk_i); @(posedge clk_i);
        #1 check_out("reset_held", '0, 1'b0, '0);
        push_i = 1'b0;
        stk.delete();
        snap_stk.delete();
        #2 rst_ni = 1'b1;
        step(0, 1, 0, 32'hA5);

`ifdef RAS_CIRC_CKPT_EN
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'h100);
        step(0, 0, 0, '0, 1'b1, 1'b0);
        step(0, 1, 0, 32'h200);
        step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0, 1'b0, 1'b1);
        drain("drain_ckpt");
        #1 check_out("ckpt_restore", 32'h100, 1'b1, CW'(1));
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        step(0, 0, 0, '0);
        drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ras_circ.md
RAS_CIRC -- requirements
Module: ras_circ

Interface
REQ-001 SHALL provide parameter XLEN, default 32, return-address width (cva6_cfg.XLEN).
REQ-002 SHALL provide parameter DEPTH, default 2, entry count (cva6_cfg.RASDepth); power of two, >=2, elaboration error otherwise.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all entries.
REQ-006 SHALL have port push_i  input  1  call detected; push data_i.
REQ-007 SHALL have port pop_i  input  1  return detected; pop top.
REQ-008 SHALL have port data_i  input  XLEN  return address to push.
REQ-009 SHALL have port data_o  output  XLEN  top-entry address.
REQ-010 SHALL have port valid_o  output  1  top entry valid (count_o != 0).
REQ-011 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-012 SHALL hold DEPTH entries {addr} in a circular array, top pointer tp ($clog2(DEPTH) bits, modulo-DEPTH wrap) and saturating count.
REQ-013 SHALL drive data_o = entry[tp], valid_o = (count != 0), count_o = count, all combinationally from registers; an update is visible the cycle after the request.
REQ-014 Push only: tp <= tp+1 (wrap), entry[tp+1] <= data_i, count <= min(count+1, DEPTH).
REQ-015 Push when count == DEPTH SHALL overwrite the oldest entry silently (overflow), with count staying DEPTH.
REQ-016 Pop only, count > 0: tp <= tp-1 (wrap), count <= count-1; entry contents unchanged.
REQ-017 Pop only, count == 0: no state change (underflow ignored).
REQ-018 Push and pop in the same cycle: entry[tp] <= data_i, tp unchanged, count <= max(count,1).
REQ-019 flush_i SHALL take priority over push/pop: count <= 0, tp <= 0 next cycle; entry contents need not be cleared.
REQ-020 Arithmetic on tp and count SHALL be width-exact with no silent truncation beyond the defined wrap of tp.

Reset
REQ-021 While rst_ni is low: tp = 0, count = 0, all entries = 0, so data_o = 0, valid_o = 0, count_o = 0, regardless of clock.
REQ-022 Reset asserted mid-operation SHALL abandon any in-flight update; the first edge after deassertion SHALL process inputs normally.

Configuration
REQ-023 Macro RAS_CIRC_CKPT_EN, when defined, SHALL add ports ckpt_i (input 1) and restore_i (input 1) plus a snapshot register {tp, count, entry[tp]}.
REQ-024 With RAS_CIRC_CKPT_EN: ckpt_i SHALL capture the pre-update state of the same cycle.
REQ-025 With RAS_CIRC_CKPT_EN: restore_i SHALL reload tp and count and rewrite entry[tp] with the saved address.
REQ-026 With RAS_CIRC_CKPT_EN: priority SHALL be flush_i > restore_i > push/pop.
REQ-027 With RAS_CIRC_CKPT_EN: ckpt_i with restore_i SHALL leave the snapshot equal to the restored state.
REQ-028 With RAS_CIRC_CKPT_EN: reset SHALL clear the snapshot to zero.
REQ-029 Without RAS_CIRC_CKPT_EN: the ports and snapshot register SHALL be absent; behaviour per REQ-012..022 only.

Verification (XLEN=32, DEPTH=4)
REQ-030 Reset; push 0x100, push 0x200 -> data_o=0x200, count_o=2; pop -> data_o=0x100, count_o=1.
REQ-031 Push 0x10,0x20,0x30,0x40,0x50 -> count_o=4, data_o=0x50; four pops yield 0x40,0x30,0x20 on data_o; after the 4th pop valid_o=0.
REQ-032 Pop on empty -> count_o=0, valid_o=0; then push 0xA0 -> data_o=0xA0, count_o=1.
REQ-033 Top 0x100 and count 2; push+pop with data_i=0x300 -> data_o=0x300, count_o=2; then pop -> prior entry shown, count_o=1.
REQ-034 flush_i with push_i set, count 3 -> next cycle count_o=0, valid_o=0; rst_ni low mid-push -> all outputs 0 immediately.
REQ-035 RAS_CIRC_CKPT_EN: push 0x100, ckpt, push 0x200, pop, pop, restore -> data_o=0x100, count_o=1, valid_o=1.
